// File: rtl/controlador_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// States, opcodes and datapath mux encodings.
package controlador_pkg;

  typedef enum logic [3:0] {
    BUSCA      = 4'd0,
    CARREGA_IR = 4'd1,
    DECODE     = 4'd2,
    EXEC_ARIT  = 4'd3,
    WB_ARIT    = 4'd4,
    CALC_END   = 4'd5,
    LE_MEM     = 4'd6,
    WB_LOAD    = 4'd7,
    ESC_MEM    = 4'd8,
    BRANCH     = 4'd9,
    JUMP       = 4'd10,
    EXEC_ADDI  = 4'd11,
    WB_ADDI    = 4'd12,
    EXCECAO    = 4'd13
  } estado_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ULA_ADD   = 2'b00;
  localparam logic [1:0] ULA_SUB   = 2'b01;
  localparam logic [1:0] ULA_FUNCT = 2'b10;
  localparam logic [1:0] ULA_IDLE  = 2'b11;

  localparam logic [1:0] PCF_ULA    = 2'b00;
  localparam logic [1:0] PCF_ALUOUT = 2'b01;
  localparam logic [1:0] PCF_JUMP   = 2'b10;

  localparam logic [1:0] ULB_REG    = 2'b00;
  localparam logic [1:0] ULB_QUATRO = 2'b01;
  localparam logic [1:0] ULB_IMM    = 2'b10;
  localparam logic [1:0] ULB_IMM_SH = 2'b11;

  function automatic int unsigned larg_contador(int unsigned w);
    return (w == 0) ? 1 : $clog2(w + 1);
  endfunction

  function automatic logic eh_estado_mem(estado_e s);
    return (s == BUSCA) || (s == LE_MEM) || (s == ESC_MEM);
  endfunction

endpackage

// File: rtl/controlador_multiciclo_contador_espera.sv
// Memory wait logic: fixed-count dwell or ready handshake.
// done_o is high in the last cycle of a memory state.
module contador_espera
  import controlador_pkg::*;
#(
  parameter int unsigned MEM_WAIT      = 2,
  parameter bit          USE_MEM_READY = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic mem_pronta_i,
  output logic done_o
);

  if (USE_MEM_READY) begin : g_hs
    logic unused_hs;
    assign unused_hs = clk_i ^ rst_i;
    assign done_o = start_i & mem_pronta_i;
  end else begin : g_cnt
    localparam int unsigned CW = larg_contador(MEM_WAIT);
    localparam logic [CW-1:0] CARGA = CW'(MEM_WAIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          unused_pronta;

    assign unused_pronta = mem_pronta_i;

    // Count down while in a memory state; reload otherwise or on exit.
    always_comb begin
      cnt_d = CARGA;
      if (start_i && (cnt_q != '0))
        cnt_d = cnt_q - 1'b1;
    end

    // Counter register, reset to a full dwell.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= CARGA;
      else       cnt_q <= cnt_d;
    end

    assign done_o = start_i & (cnt_q == '0);
  end

endmodule

// File: rtl/controlador_multiciclo.sv
// Multicycle MIPS control unit: fetch/decode/execute/mem/write-back.
// Outputs decode straight from state and OpCode.
module controlador_multiciclo
  import controlador_pkg::*;
#(
  parameter int unsigned MEM_WAIT      = 2,
  parameter bit          USE_MEM_READY = 1'b0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [5:0] OpCode,
  input  logic       MemPronta,
  output logic       PCEsc,
  output logic       PCEscCond,
  output logic       BranchNe,
  output logic [1:0] PCFonte,
  output logic       CtrMem,
  output logic       IouD,
  output logic       IREsc,
  output logic       MDREsc,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemParaReg,
  output logic       ULAFonteA,
  output logic [1:0] ULAFonteB,
  output logic [1:0] ULAOp,
  output logic       Invalida,
  output logic [3:0] state
);

  estado_e state_q;
  estado_e state_d;
  logic    mem_st;
  logic    mem_done;

  assign mem_st = eh_estado_mem(state_q);
  assign state  = state_q;

  contador_espera #(
    .MEM_WAIT      (MEM_WAIT),
    .USE_MEM_READY (USE_MEM_READY)
  ) u_espera (
    .clk_i        (Clock),
    .rst_i        (Reset),
    .start_i      (mem_st),
    .mem_pronta_i (MemPronta),
    .done_o       (mem_done)
  );

  // Next-state selection and opcode dispatch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BUSCA:      if (mem_done) state_d = CARREGA_IR;
      CARREGA_IR: state_d = DECODE;
      DECODE: begin
        case (OpCode)
          OP_R:           state_d = EXEC_ARIT;
          OP_LW, OP_SW:   state_d = CALC_END;
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_J:           state_d = JUMP;
          OP_ADDI:        state_d = EXEC_ADDI;
          default:        state_d = EXCECAO;
        endcase
      end
      EXEC_ARIT:  state_d = WB_ARIT;
      CALC_END:   state_d = (OpCode == OP_SW) ? ESC_MEM : LE_MEM;
      LE_MEM:     if (mem_done) state_d = WB_LOAD;
      ESC_MEM:    if (mem_done) state_d = BUSCA;
      EXEC_ADDI:  state_d = WB_ADDI;
      default:    state_d = BUSCA;
    endcase
  end

  // State register; reset drops any instruction in flight.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= BUSCA;
    else       state_q <= state_d;
  end

  // Datapath controls per state.
  always_comb begin
    PCEsc      = 1'b0;
    PCEscCond  = 1'b0;
    BranchNe   = 1'b0;
    PCFonte    = PCF_ULA;
    CtrMem     = 1'b0;
    IouD       = 1'b0;
    IREsc      = 1'b0;
    MDREsc     = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemParaReg = 1'b0;
    ULAFonteA  = 1'b0;
    ULAFonteB  = ULB_REG;
    ULAOp      = ULA_IDLE;
    Invalida   = 1'b0;
    case (state_q)
      CARREGA_IR: begin
        IREsc     = 1'b1;
        PCEsc     = 1'b1;
        ULAFonteB = ULB_QUATRO;
        ULAOp     = ULA_ADD;
        PCFonte   = PCF_ULA;
      end
      DECODE: begin
        ULAFonteB = ULB_IMM_SH;
        ULAOp     = ULA_ADD;
      end
      EXEC_ARIT: begin
        ULAFonteA = 1'b1;
        ULAOp     = ULA_FUNCT;
      end
      WB_ARIT: begin
        ULAFonteA = 1'b1;
        ULAOp     = ULA_FUNCT;
        RegDst    = 1'b1;
        RegWrite  = 1'b1;
      end
      CALC_END, EXEC_ADDI: begin
        ULAFonteA = 1'b1;
        ULAFonteB = ULB_IMM;
        ULAOp     = ULA_ADD;
      end
      WB_ADDI: begin
        ULAFonteA = 1'b1;
        ULAFonteB = ULB_IMM;
        ULAOp     = ULA_ADD;
        RegWrite  = 1'b1;
      end
      LE_MEM: begin
        IouD   = 1'b1;
        MDREsc = 1'b1;
      end
      WB_LOAD: begin
        MemParaReg = 1'b1;
        RegWrite   = 1'b1;
      end
      ESC_MEM: begin
        IouD   = 1'b1;
        CtrMem = 1'b1;
      end
      BRANCH: begin
        ULAFonteA = 1'b1;
        ULAOp     = ULA_SUB;
        PCEscCond = 1'b1;
        PCFonte   = PCF_ALUOUT;
        BranchNe  = OpCode[0];
      end
      JUMP: begin
        PCEsc   = 1'b1;
        PCFonte = PCF_JUMP;
      end
      EXCECAO:  Invalida = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controlador_multiciclo.sv
// Directed bench for controlador_multiciclo.
// Four instances: W=2, W=0, W=3 and handshake mode.
module tb_controlador_multiciclo;

  typedef struct packed {
    logic       pc_esc;
    logic       pc_esc_cond;
    logic       branch_ne;
    logic [1:0] pc_fonte;
    logic       ctr_mem;
    logic       iou_d;
    logic       ir_esc;
    logic       mdr_esc;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_para_reg;
    logic       ula_fonte_a;
    logic [1:0] ula_fonte_b;
    logic [1:0] ula_op;
    logic       invalida;
    logic [3:0] state;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst [4];
  logic [5:0] op  [4];
  logic       pr  [4];
  outs_t      o   [4];

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    outs_t ov;
    assign o[g] = ov;
    controlador_multiciclo #(
      .MEM_WAIT      (g == 0 ? 2 : (g == 2 ? 3 : 0)),
      .USE_MEM_READY (g == 3)
    ) u_dut (
      .Clock      (clk),
      .Reset      (rst[g]),
      .OpCode     (op[g]),
      .MemPronta  (pr[g]),
      .PCEsc      (ov.pc_esc),
      .PCEscCond  (ov.pc_esc_cond),
      .BranchNe   (ov.branch_ne),
      .PCFonte    (ov.pc_fonte),
      .CtrMem     (ov.ctr_mem),
      .IouD       (ov.iou_d),
      .IREsc      (ov.ir_esc),
      .MDREsc     (ov.mdr_esc),
      .RegWrite   (ov.reg_write),
      .RegDst     (ov.reg_dst),
      .MemParaReg (ov.mem_para_reg),
      .ULAFonteA  (ov.ula_fonte_a),
      .ULAFonteB  (ov.ula_fonte_b),
      .ULAOp      (ov.ula_op),
      .Invalida   (ov.invalida),
      .state      (ov.state)
    );
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int g, input int st, input int budget);
    int n;
    n = 0;
    while (int'(o[g].state) != st && n < budget) begin
      tick();
      n++;
    end
    chk("reach_state", int'(o[g].state), st);
  endtask

  int e_r [8]  = '{0, 0, 0, 1, 2, 3, 4, 0};
  int e_lw[7]  = '{0, 1, 2, 5, 6, 7, 0};
  int e_rs[5]  = '{0, 0, 0, 0, 1};

  initial begin
    outs_t def;
    int    n_ir, n_pc, run, max_run, n_sw, n_rw;
    def        = '0;
    def.ula_op = 2'b11;
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1;
      op[i]  = 6'b000000;
      pr[i]  = 1'b0;
    end
    tick();
    tick();
    chk("rst_outs0", int'(o[0]), int'(def));
    chk("rst_outs3", int'(o[3]), int'(def));

    // R-type, W=2
    rst[0] = 1'b0;
    n_ir = 0;
    n_pc = 0;
    for (int k = 1; k <= 8; k++) begin
      chk("r_state", int'(o[0].state), e_r[k-1]);
      n_ir += int'(o[0].ir_esc);
      n_pc += int'(o[0].pc_esc);
      if (k == 7) begin
        chk("r_regwrite", int'(o[0].reg_write), 1);
        chk("r_regdst", int'(o[0].reg_dst), 1);
      end
      tick();
    end
    chk("r_iresc_cnt", n_ir, 1);
    chk("r_pcesc_cnt", n_pc, 1);

    // lw, W=0
    op[1]  = 6'b100011;
    rst[1] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      chk("lw_state", int'(o[1].state), e_lw[k-1]);
      if (k == 5) begin
        chk("lw_ioud", int'(o[1].iou_d), 1);
        chk("lw_mdresc", int'(o[1].mdr_esc), 1);
      end
      if (k == 6) begin
        chk("lw_memparareg", int'(o[1].mem_para_reg), 1);
        chk("lw_regwrite", int'(o[1].reg_write), 1);
      end
      tick();
    end

    // sw, W=3
    op[2]  = 6'b101011;
    rst[2] = 1'b0;
    run = 0;
    max_run = 0;
    n_sw = 0;
    n_rw = 0;
    for (int k = 1; k <= 12; k++) begin
      if (o[2].ctr_mem && o[2].iou_d) begin
        run++;
        n_sw++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      n_rw += int'(o[2].reg_write);
      if (k == 11) chk("sw_last_escmem", int'(o[2].state), 8);
      if (k == 12) chk("sw_back_busca", int'(o[2].state), 0);
      tick();
    end
    chk("sw_ctrmem_cnt", n_sw, 4);
    chk("sw_ctrmem_run", max_run, 4);
    chk("sw_regwrite_cnt", n_rw, 0);

    // bne, beq, j on W=2
    op[0] = 6'b000101;
    run_to(0, 9, 30);
    chk("bne_pcesccond", int'(o[0].pc_esc_cond), 1);
    chk("bne_pcfonte", int'(o[0].pc_fonte), 1);
    chk("bne_ulaop", int'(o[0].ula_op), 1);
    chk("bne_branchne", int'(o[0].branch_ne), 1);
    tick();
    op[0] = 6'b000100;
    run_to(0, 9, 30);
    chk("beq_branchne", int'(o[0].branch_ne), 0);
    chk("beq_pcesccond", int'(o[0].pc_esc_cond), 1);
    tick();
    op[0] = 6'b000010;
    run_to(0, 10, 30);
    chk("j_pcesc", int'(o[0].pc_esc), 1);
    chk("j_pcfonte", int'(o[0].pc_fonte), 2);

    // handshake, illegal opcode
    op[3]  = 6'b111111;
    rst[3] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk("hs_wait", int'(o[3].state), 0);
      tick();
    end
    pr[3] = 1'b1;
    chk("hs_last_busca", int'(o[3].state), 0);
    tick();
    chk("hs_carrega", int'(o[3].state), 1);
    tick();
    chk("hs_decode", int'(o[3].state), 2);
    chk("hs_inv_pre", int'(o[3].invalida), 0);
    tick();
    chk("hs_excecao", int'(o[3].state), 13);
    chk("hs_inv", int'(o[3].invalida), 1);
    tick();
    chk("hs_inv_busca", int'(o[3].state), 0);
    chk("hs_inv_post", int'(o[3].invalida), 0);

    // reset in the middle of LeMem, W=3
    op[2] = 6'b100011;
    run_to(2, 6, 40);
    chk("rs_ioud", int'(o[2].iou_d), 1);
    #3;
    rst[2] = 1'b1;
    #1;
    chk("rs_state", int'(o[2].state), 0);
    chk("rs_outs", int'(o[2]), int'(def));
    tick();
    rst[2] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk("rs_dwell", int'(o[2].state), e_rs[k-1]);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/controlador_multiciclo.md
# controlador_multiciclo

Parametrised multicycle MIPS control unit, successor to the fixed-wait controller. It sequences fetch, decode, execute, memory and write-back for R-type, lw, sw, beq, bne, j and addi. Memory latency is set either by a parameter-programmed wait counter or by a ready handshake from memory. It drives the datapath muxes and write enables directly and flags illegal opcodes.

## Interface
- MEM_WAIT, 2: extra wait cycles per memory access in counter mode (0..15).
- USE_MEM_READY, 0: 1 = hold memory states until MemPronta, ignore MEM_WAIT.
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high; forces state Busca.
- OpCode  in  6  IR[31:26], stable from the cycle after CarregaIR.
- MemPronta  in  1  memory ready; used only when USE_MEM_READY=1.
- PCEsc  out  1  unconditional PC write.
- PCEscCond  out  1  conditional PC write; datapath gates it with Zero/BranchNe.
- BranchNe  out  1  1 = take branch on !Zero (bne), 0 = on Zero (beq).
- PCFonte  out  2  PC source: 00 ULA result, 01 ALUOut, 10 jump target.
- CtrMem  out  1  1 = memory write, 0 = read.
- IouD  out  1  memory address: 0 PC, 1 ALUOut.
- IREsc, MDREsc, RegWrite, RegDst, MemParaReg, ULAFonteA  out  1 each  standard datapath controls.
- ULAFonteB  out  2  00 reg B, 01 const 4, 10 signext imm, 11 signext imm<<2.
- ULAOp  out  2  00 add, 01 sub, 10 by funct, 11 idle.
- Invalida  out  1  one-cycle pulse on illegal opcode.
- state  out  4  current state encoding, for debug.

## Operation
- States and codes: Busca 0, CarregaIR 1, Decode 2, ExecArit 3, WBArit 4, CalcEnd 5, LeMem 6, WBLoad 7, EscMem 8, Branch 9, Jump 10, ExecAddi 11, WBAddi 12, Excecao 13. Codes 14-15 are illegal and go to Busca.
- Default outputs in every state: all 0, ULAOp=11. Only deviations are listed below.
- Busca: IouD=0, read. Memory state.
- CarregaIR: IREsc=1, PCEsc=1, ULAFonteB=01, ULAOp=00, PCFonte=00. Next state is Decode.
- Decode: ULAFonteB=11, ULAOp=00, giving the branch target in ALUOut. Dispatch on OpCode:
  - 000000 -> ExecArit
  - 100011 or 101011 -> CalcEnd
  - 000100 or 000101 -> Branch
  - 000010 -> Jump
  - 001000 -> ExecAddi
  - any other -> Excecao
- ExecArit: ULAFonteA=1, ULAOp=10. Next state is WBArit.
- WBArit: same as ExecArit, plus RegDst=1, RegWrite=1. Next state is Busca.
- CalcEnd: ULAFonteA=1, ULAFonteB=10, ULAOp=00. Next state is LeMem for lw, EscMem for sw.
- LeMem: IouD=1, MDREsc=1. Memory state. Next state is WBLoad.
- WBLoad: MemParaReg=1, RegWrite=1. Next state is Busca.
- EscMem: IouD=1, CtrMem=1. Memory state. Next state is Busca.
- Branch: ULAFonteA=1, ULAOp=01, PCEscCond=1, PCFonte=01, BranchNe=OpCode[0]. Next state is Busca.
- Jump: PCEsc=1, PCFonte=10. Next state is Busca.
- ExecAddi: ULAFonteA=1, ULAFonteB=10, ULAOp=00. Next state is WBAddi.
- WBAddi: same as ExecAddi, plus RegWrite=1, RegDst=0. Next state is Busca.
- Excecao: Invalida=1. Next state is Busca; the instruction is dropped and PC is already advanced.
- Memory states (Busca, LeMem, EscMem), counter mode:
  - Wait counter is loaded with MEM_WAIT on entry and decremented each cycle.
  - The state is left when the counter reads 0.
  - Dwell is MEM_WAIT+1 cycles.
- Memory states, handshake mode:
  - The state is left after a cycle with MemPronta=1.
  - Dwell is at least 1 cycle.
  - No timeout.
- Outputs are held constant for the whole dwell.

## Timing
- Reset state: state=Busca, wait counter=MEM_WAIT, all outputs at their defaults (ULAOp=11).
- Reset is asynchronous at assertion. Mid-instruction, it abandons the instruction immediately; no partial write survives past the reset edge.
- Outputs are a function of state and OpCode only; no output register stage.
- With W=MEM_WAIT, cycles per instruction in counter mode:
  - R-type and addi: W+5
  - lw: 2W+6
  - sw: 2W+5
  - beq, bne, j and illegal: W+4
- Handshake mode: MemPronta held high gives the W=0 counts.
- MemPronta asserted during a non-memory state is ignored.
- MDR holds valid data from the final LeMem cycle.

## Structure
- Package controlador_pkg:
  - state enum, 4-bit
  - opcode constants OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI
  - ULAOp encodings ULA_ADD, ULA_SUB, ULA_FUNCT, ULA_IDLE
  - PCFonte and ULAFonteB encodings
- Sub-module contador_espera:
  - inputs: start, MemPronta
  - output: done
  - implements both wait modes under the USE_MEM_READY generate.
- Wait counter width is $clog2(MEM_WAIT+1), minimum 1.

## Test plan
- MEM_WAIT=2, OpCode=000000 -> Busca lasts 3 cycles; IREsc and PCEsc pulse once; RegWrite=1 with RegDst=1 in cycle 7; back in Busca at cycle 8.
- MEM_WAIT=0, lw -> LeMem lasts 1 cycle with IouD=1, MDREsc=1; WBLoad has MemParaReg=1, RegWrite=1; 6 cycles total.
- MEM_WAIT=3, sw -> CtrMem=1, IouD=1 for exactly 4 consecutive cycles; RegWrite never asserted.
- bne (000101) then beq (000100) -> Branch has PCEscCond=1, PCFonte=01, ULAOp=01, BranchNe=1 then BranchNe=0; j gives PCEsc=1, PCFonte=10.
- USE_MEM_READY=1, MemPronta low for 5 cycles then high -> Busca lasts 6 cycles; OpCode=111111 -> Invalida pulses exactly 1 cycle, then Busca.
- Reset asserted mid-LeMem, between clock edges -> state=0 immediately; all enables 0, ULAOp=11; after release, fetch restarts with full MEM_WAIT dwell.
